// File: rtl/spinner_step_gen.sv
// Synchronous prescaler producing a one-cycle step_tick; SPINNER_SINGLE_STEP_EN adds a debounced single-step button.
// Pad inputs take effect 2 cycles after they change; step_tick rises 2^k cycles after reset release; no backpressure.
module spinner_step_gen #(
  parameter int PRESCALE_W = 13,
  parameter int DEB_W      = 10,
  parameter int TICKCNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           rate_sel,
  input  logic                 pause,
  input  logic                 step_btn,
  output logic                 step_tick,
  output logic                 paused,
  output logic [TICKCNT_W-1:0] tick_count
);

  localparam int K0 = PRESCALE_W - 2;
  localparam int K1 = PRESCALE_W - 1;
  localparam int K2 = PRESCALE_W;
  localparam int K3 = (PRESCALE_W - 4 > 1) ? PRESCALE_W - 4 : 1;

  localparam logic [PRESCALE_W:0]   ONE   = (PRESCALE_W+1)'(1);
  localparam logic [PRESCALE_W-1:0] MASK0 = PRESCALE_W'((ONE << K0) - ONE);
  localparam logic [PRESCALE_W-1:0] MASK1 = PRESCALE_W'((ONE << K1) - ONE);
  localparam logic [PRESCALE_W-1:0] MASK2 = PRESCALE_W'((ONE << K2) - ONE);
  localparam logic [PRESCALE_W-1:0] MASK3 = PRESCALE_W'((ONE << K3) - ONE);

  logic [1:0]            rate_s1, rate_s2;
  logic                  pause_s1, pause_s2;
  logic [PRESCALE_W-1:0] prescale_cnt;
  logic [PRESCALE_W-1:0] tap_mask;
  logic                  prescale_hit;
  logic                  btn_rise;
  logic                  fire;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate_s1  <= 2'b00;
      rate_s2  <= 2'b00;
      pause_s1 <= 1'b0;
      pause_s2 <= 1'b0;
    end else begin
      rate_s1  <= rate_sel;
      rate_s2  <= rate_s1;
      pause_s1 <= pause;
      pause_s2 <= pause_s1;
    end
  end

  assign paused = pause_s2;

  always_comb begin
    tap_mask = MASK0;
    case (rate_s2)
      2'd0:    tap_mask = MASK0;
      2'd1:    tap_mask = MASK1;
      2'd2:    tap_mask = MASK2;
      default: tap_mask = MASK3;
    endcase
  end

  // Low k bits all ones; consecutive counts can never both satisfy this, so a rate switch cannot double-pulse.
  assign prescale_hit = &(prescale_cnt | ~tap_mask);

`ifdef SPINNER_SINGLE_STEP_EN
  logic             btn_s1, btn_s2;
  logic             deb_level;
  logic [DEB_W-1:0] deb_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      btn_s1 <= step_btn;
      btn_s2 <= btn_s1;
      if (btn_s2 == deb_level) begin
        deb_cnt <= '0;
      end else if (&deb_cnt) begin
        deb_level <= btn_s2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Debounced rising edge, honoured only while stepping is held.
  assign btn_rise = btn_s2 && !deb_level && (&deb_cnt) && pause_s2;
`else
  logic unused_btn;
  assign unused_btn = step_btn & (DEB_W > 0);
  assign btn_rise   = 1'b0;
`endif

  assign fire = ((prescale_hit && !pause_s2) || btn_rise) && !step_tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescale_cnt <= '0;
      step_tick    <= 1'b0;
      tick_count   <= '0;
    end else begin
      if (!pause_s2) begin
        prescale_cnt <= prescale_cnt + 1'b1;
      end
      step_tick <= fire;
      if (fire) begin
        tick_count <= tick_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spinner_step_gen.sv
// Scoreboard bench for spinner_step_gen with PRESCALE_W=6, DEB_W=3, TICKCNT_W=8.
module tb_spinner_step_gen;

`ifdef SPINNER_SINGLE_STEP_EN
  localparam int SS = 1;
`else
  localparam int SS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] rate_sel;
  logic       pause;
  logic       step_btn;
  logic       step_tick;
  logic       paused;
  logic [7:0] tick_count;

  spinner_step_gen #(.PRESCALE_W(6), .DEB_W(3), .TICKCNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rate_sel   (rate_sel),
    .pause      (pause),
    .step_btn   (step_btn),
    .step_tick  (step_tick),
    .paused     (paused),
    .tick_count (tick_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] cnt; } tick_t;
  typedef struct { int cyc; int tag; logic tk; logic pau; logic [7:0] cnt; } chk_t;

  tick_t exp_q[$];
  chk_t  chk_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  logic  prev_tick = 1'b0;

  task automatic exp_tick(input int c, input int n);
    tick_t t;
    t.cyc = c;
    t.cnt = 8'(n);
    exp_q.push_back(t);
  endtask

  task automatic exp_state(input int tag, input int c, input logic tk, input logic p, input int n);
    chk_t k;
    k.cyc = c; k.tag = tag; k.tk = tk; k.pau = p; k.cnt = 8'(n);
    chk_q.push_back(k);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    tick_t t;
    chk_t  k;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      t = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missed_tick expected at cyc %0d (count %0d), now cyc %0d", t.cyc, t.cnt, cyc);
    end
    if (step_tick) begin
      n_vec++;
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        n_err++;
        $display("FAIL unexpected_tick at cyc %0d tick_count=%0d", cyc, tick_count);
      end else begin
        t = exp_q.pop_front();
        if (t.cnt != tick_count || prev_tick) begin
          n_err++;
          $display("FAIL tick cyc %0d: tick_count=%0d prev_tick=%0b, required count=%0d prev_tick=0",
                   cyc, tick_count, prev_tick, t.cnt);
        end
      end
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      k = chk_q.pop_front();
      n_vec++;
      if (step_tick !== k.tk || paused !== k.pau || tick_count !== k.cnt) begin
        n_err++;
        $display("FAIL state_%0d cyc %0d: tick=%0b paused=%0b count=%0d, required tick=%0b paused=%0b count=%0d",
                 k.tag, cyc, step_tick, paused, tick_count, k.tk, k.pau, k.cnt);
      end
    end
    prev_tick = step_tick;
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic rst_release(input logic [1:0] r, output int c);
    rst_n    = 1'b0;
    rate_sel = r;
    pause    = 1'b0;
    step_btn = 1'b0;
    repeat (3) @(negedge clk);
    c     = cyc;
    rst_n = 1'b1;
  endtask

  // Bouncy press: bursts shorter than 8 cycles, then 20 stable cycles, then release.
  task automatic btn_seq();
    step_btn = 1'b1; repeat (3)  @(negedge clk);
    step_btn = 1'b0; repeat (2)  @(negedge clk);
    step_btn = 1'b1; repeat (5)  @(negedge clk);
    step_btn = 1'b0; repeat (1)  @(negedge clk);
    step_btn = 1'b1; repeat (20) @(negedge clk);
    step_btn = 1'b0;
  endtask

  initial begin
    int c;
    int r;
    int x;
    int w;
    rst_n    = 1'b0;
    rate_sel = 2'd2;
    pause    = 1'b1;
    step_btn = 1'b0;

    // Reset state, with pause held high at the pad.
    exp_state(1, 4, 1'b0, 1'b0, 0);
    exp_state(2, 5, 1'b0, 1'b0, 0);
    wait_to(5);
    pause = 1'b0;
    wait_to(8);
    c     = cyc;
    rst_n = 1'b1;
    exp_tick(c + 64, 1);
    exp_tick(c + 128, 2);
    exp_tick(c + 192, 3);
    exp_state(3, c + 194, 1'b0, 1'b0, 3);
    wait_to(c + 200);

    // Rate 0 then 3.
    rst_release(2'd0, c);
    exp_tick(c + 16, 1);
    exp_tick(c + 32, 2);
    exp_tick(c + 48, 3);
    wait_to(c + 50);
    rate_sel = 2'd3;
    for (int i = 0; i < 4; i++) exp_tick(c + 56 + 4*i, 4 + i);
    wait_to(c + 70);

    // Pause mid-interval for 100 cycles.
    rst_release(2'd0, c);
    exp_tick(c + 16, 1);
    exp_state(10, c + 21, 1'b0, 1'b0, 1);
    exp_state(11, c + 22, 1'b0, 1'b1, 1);
    exp_state(12, c + 60, 1'b0, 1'b1, 1);
    exp_state(13, c + 121, 1'b0, 1'b1, 1);
    exp_state(14, c + 130, 1'b0, 1'b0, 1);
    wait_to(c + 20);
    pause = 1'b1;
    wait_to(c + 120);
    pause = 1'b0;
    exp_tick(c + 132, 2);
    exp_tick(c + 148, 3);
    wait_to(c + 150);

    // tick_count wrap, then reset on a would-be tick edge.
    rst_release(2'd3, c);
    for (int i = 1; i <= 257; i++) exp_tick(c + 4*i, i % 256);
    exp_state(20, c + 1030, 1'b0, 1'b0, 1);
    exp_state(21, c + 1032, 1'b0, 1'b0, 0);
    wait_to(c + 1031);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    r     = cyc;
    rst_n = 1'b1;
    exp_tick(r + 4, 1);
    exp_tick(r + 8, 2);
    wait_to(r + 10);

    // Single-step button while paused, then while running.
    rst_release(2'd2, c);
    pause = 1'b1;
    wait_to(c + 5);
    x = cyc;
    if (SS != 0) exp_tick(x + 21, 1);
    exp_state(30, x + 25, 1'b0, 1'b1, SS);
    btn_seq();
    wait_to(x + 45);
    w     = cyc;
    pause = 1'b0;
    exp_tick(w + 64, SS + 1);
    exp_state(31, w + 50, 1'b0, 1'b0, SS);
    wait_to(w + 5);
    btn_seq();
    wait_to(w + 70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
